axil_selftest_master: RTL and testbench
=======================================

# axil_selftest_master

Synthesizable AXI4-Lite master that exercises the `inputoutput` register slave from inside the fabric, upstream of its S00_AXI port. On a start pulse it writes NUM_REGS sequential words (seed, seed+1, …) to consecutive 32-bit registers. It then reads each register back, compares against the written value and reports pass/fail, error count and first failing address. Used for power-on self-test and as a fabric-side replacement for the VIP master sequence.

## Interface
- C_M_AXI_ADDR_WIDTH, 32, address width
- C_M_AXI_DATA_WIDTH, 32, data width (only 32 supported)
- NUM_REGS, 4, registers exercised (1..16)
- BASE_ADDR, 32'h0, address of register 0; register i at BASE_ADDR + 4*i
- TIMEOUT_CYCLES, 1024, max cycles waiting on any single handshake
- ACLK  in  1  clock
- ARESETN  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- seed  in  32  first write value; sampled with start
- busy  out  1  high from the cycle after start until DONE
- done  out  1  one-cycle pulse at end of sequence
- pass  out  1  result; valid from done until next start
- err_cnt  out  8  mismatches + bad responses + timeouts, saturating at 255
- fail_addr  out  ADDR_WIDTH  address of first error; 0 if none
- timeout  out  1  sticky; set if the sequence was aborted by timeout
- M_AXI_AWADDR/AWPROT/AWVALID  out  ADDR/3/1; AWREADY in 1
- M_AXI_WDATA/WSTRB/WVALID  out  DATA/DATA/8/1; WREADY in 1
- M_AXI_BRESP in 2, BVALID in 1, BREADY out 1
- M_AXI_ARADDR/ARPROT/ARVALID  out  ADDR/3/1; ARREADY in 1
- M_AXI_RDATA in DATA, RRESP in 2, RVALID in 1, RREADY out 1

## Operation
- States: IDLE → WR_REQ → WR_RESP → (next reg, or RD_REQ after the last write) → RD_REQ → RD_DATA → (next reg, or FIN after the last read) → FIN → IDLE.
- IDLE:
  - On start, latch seed, clear err_cnt, fail_addr, timeout and pass.
  - Set idx=0, go to WR_REQ.
  - start outside IDLE is ignored.
- WR_REQ:
  - Assert AWVALID and WVALID together.
  - AWADDR = BASE_ADDR+4*idx, WDATA = seed+idx (mod 2^32), WSTRB = all ones, AWPROT = ARPROT = 0.
  - Each valid drops independently the cycle after its own handshake.
  - Leave WR_REQ when both handshakes have completed, including the case where both complete in the same cycle.
- WR_RESP:
  - BREADY=1.
  - On BVALID, BRESP≠OKAY counts one error.
  - Then idx+1, or reset idx=0 and go to RD_REQ.
- RD_REQ: ARVALID with ARADDR = BASE_ADDR+4*idx until ARREADY.
- RD_DATA:
  - RREADY=1.
  - On RVALID, RRESP≠OKAY counts one error.
  - Separately, RDATA≠seed+idx counts one error. Both errors can occur on one beat, giving +2.
- Error on any register: the first error sets fail_addr to that register's address; later errors do not update it.
- FIN:
  - done=1 for one cycle.
  - pass = (err_cnt==0 && !timeout).
  - Return to IDLE.
- Timeout:
  - The counter restarts on entry to each of WR_REQ, WR_RESP, RD_REQ and RD_DATA.
  - When it reaches TIMEOUT_CYCLES without the state completing: set timeout, increment err_cnt, record fail_addr if it is the first error, drop all valids/readies and go to FIN.
  - Dropping a valid here is a deliberate hang-recovery deviation from the AXI protocol.

## Timing
- Reset: all valids/readies, busy, done, pass, timeout = 0; err_cnt = 0; fail_addr = 0; state IDLE.
- Reset mid-sequence drops every output to these values immediately (asynchronous) and abandons the sequence.
- start in cycle N: busy and AWVALID/WVALID are high in N+1.
- Zero-wait slave (ready held high, response on the cycle after the handshake): 2 cycles per write and 2 per read.
  - NUM_REGS=4 gives done 17 cycles after start.
- done and the pass update occur in the same cycle. busy is low in that cycle.
- Outputs are registered. No combinational path exists from any READY/VALID input to any VALID/READY output.

## Structure
- Package axil_selftest_pkg holds:
  - state enum
  - response constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10
  - the saturating-increment function used for err_cnt
- One sub-module, axil_seq_timer: load/clear, enable, expired flag, width $clog2(TIMEOUT_CYCLES+1).
- Everything else lives in the top FSM.

## Test plan
- Zero-wait slave, seed=32'h1:
  - Writes 1,2,3,4 to 0x0,0x4,0x8,0xC; reads match.
  - done at start+17; pass=1, err_cnt=0.
- Random AWREADY/WREADY skew with WREADY 3 cycles before AWREADY: WVALID drops after its handshake, AWVALID is held; no duplicate write; pass=1.
- Slave corrupts register 2 readback to 32'hDEAD: err_cnt=1, fail_addr=0x8, pass=0.
- Slave returns SLVERR on write 1 and on read 3 with correct data: err_cnt=2, fail_addr=0x4.
- ARREADY held low: after 1024 cycles in RD_REQ, timeout=1, err_cnt=1, fail_addr=0x0, done pulses, ARVALID drops.
- ARESETN pulsed low during WR_RESP of register 2:
  - All outputs return to reset values asynchronously.
  - A subsequent start with seed=32'hFFFF_FFFF writes FFFF_FFFF, 0, 1, 2 (wrap) and passes.

Source files
------------

// File: rtl/axil_selftest_pkg.sv
// axil_selftest_pkg: shared state encoding, AXI response codes and saturating counter helper
package axil_selftest_pkg;
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, FIN} state_t;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [1:0] n);
    logic [8:0] s;
    s = {1'b0, v} + {7'b0, n};
    return s[8] ? 8'hFF : s[7:0];
  endfunction
endpackage

// File: rtl/axil_seq_timer.sv
// axil_seq_timer: per-state handshake watchdog; expired after TIMEOUT_CYCLES cycles since the last clear
module axil_seq_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  logic [W-1:0] cnt;
  assign expired = cnt == W'(TIMEOUT_CYCLES - 1);
  // count cycles spent in the current state, holding once expired
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && !expired) cnt <= cnt + 1'b1;
endmodule

// File: rtl/axil_selftest_master.sv
// axil_selftest_master: AXI4-Lite master writing seed+i to NUM_REGS registers, reading back and scoring the result
module axil_selftest_master
  import axil_selftest_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int NUM_REGS = 4,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic                            start,
  input  logic [31:0]                     seed,
  output logic                            busy,
  output logic                            done,
  output logic                            pass,
  output logic [7:0]                      err_cnt,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   fail_addr,
  output logic                            timeout,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);
  state_t state, nxt;
  logic [4:0] idx, idx_d;
  logic [31:0] seed_q, seed_d, exp_data;
  logic [C_M_AXI_ADDR_WIDTH-1:0] cur_addr, fail_addr_d;
  logic [7:0] err_d;
  logic [1:0] n_err;
  logic go, last, wr_ok, step_ok, in_seq, expired, expire, e_b, e_r, e_d;
  logic awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d, busy_d, done_d, pass_d, timeout_d;

  assign go = state == IDLE && start;
  assign last = idx == 5'(NUM_REGS - 1);
  assign cur_addr = BASE_ADDR + C_M_AXI_ADDR_WIDTH'({idx, 2'b00});
  assign exp_data = seed_q + 32'(idx);
  assign wr_ok = (!M_AXI_AWVALID || M_AXI_AWREADY) && (!M_AXI_WVALID || M_AXI_WREADY);
  assign in_seq = state inside {WR_REQ, WR_RESP, RD_REQ, RD_DATA};
  assign step_ok = state == WR_REQ ? wr_ok : state == WR_RESP ? M_AXI_BVALID :
                   state == RD_REQ ? M_AXI_ARREADY : state == RD_DATA ? M_AXI_RVALID : 1'b0;
  assign expire = in_seq && expired && !step_ok;
  assign M_AXI_AWADDR = cur_addr;
  assign M_AXI_ARADDR = cur_addr;
  assign M_AXI_WDATA = exp_data;
  assign M_AXI_WSTRB = '1;
  assign M_AXI_AWPROT = '0;
  assign M_AXI_ARPROT = '0;

  axil_seq_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk(ACLK), .rst_n(ARESETN), .clr(nxt != state), .en(1'b1), .expired(expired)
  );

  // state and every registered output/datapath value
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      state <= IDLE;
      idx <= '0;
      seed_q <= '0;
      err_cnt <= '0;
      fail_addr <= '0;
      timeout <= 1'b0;
      pass <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID <= 1'b0;
      M_AXI_BREADY <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY <= 1'b0;
    end else begin
      state <= nxt;
      idx <= idx_d;
      seed_q <= seed_d;
      err_cnt <= err_d;
      fail_addr <= fail_addr_d;
      timeout <= timeout_d;
      pass <= pass_d;
      busy <= busy_d;
      done <= done_d;
      M_AXI_AWVALID <= awvalid_d;
      M_AXI_WVALID <= wvalid_d;
      M_AXI_BREADY <= bready_d;
      M_AXI_ARVALID <= arvalid_d;
      M_AXI_RREADY <= rready_d;
    end

  // sequence walk; a watchdog expiry in any bus state aborts straight to FIN
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = start ? WR_REQ : IDLE;
      WR_REQ:  nxt = wr_ok ? WR_RESP : WR_REQ;
      WR_RESP: nxt = M_AXI_BVALID ? (last ? RD_REQ : WR_REQ) : WR_RESP;
      RD_REQ:  nxt = M_AXI_ARREADY ? RD_DATA : RD_REQ;
      RD_DATA: nxt = M_AXI_RVALID ? (last ? FIN : RD_REQ) : RD_DATA;
      default: nxt = IDLE;
    endcase
    if (expire) nxt = FIN;
  end

  // next values of the registered outputs, derived from the upcoming state so they appear on entry
  always_comb begin
    e_b = state == WR_RESP && M_AXI_BVALID && M_AXI_BRESP != RESP_OKAY;
    e_r = state == RD_DATA && M_AXI_RVALID && M_AXI_RRESP != RESP_OKAY;
    e_d = state == RD_DATA && M_AXI_RVALID && M_AXI_RDATA != exp_data;
    n_err = {1'b0, e_b} + {1'b0, e_r} + {1'b0, e_d} + {1'b0, expire};
    seed_d = go ? seed : seed_q;
    err_d = go ? '0 : sat_inc(err_cnt, n_err);
    fail_addr_d = go ? '0 : (n_err != 2'd0 && err_cnt == 8'd0) ? cur_addr : fail_addr;
    timeout_d = go ? 1'b0 : timeout | expire;
    pass_d = go ? 1'b0 : nxt == FIN ? (err_d == 8'd0 && !timeout_d) : pass;
    idx_d = go ? '0 : (state == WR_RESP && M_AXI_BVALID) ? (last ? '0 : idx + 5'd1) :
            (state == RD_DATA && M_AXI_RVALID) ? idx + 5'd1 : idx;
    awvalid_d = nxt == WR_REQ && (state != WR_REQ || (M_AXI_AWVALID && !M_AXI_AWREADY));
    wvalid_d = nxt == WR_REQ && (state != WR_REQ || (M_AXI_WVALID && !M_AXI_WREADY));
    bready_d = nxt == WR_RESP;
    arvalid_d = nxt == RD_REQ;
    rready_d = nxt == RD_DATA;
    busy_d = nxt inside {WR_REQ, WR_RESP, RD_REQ, RD_DATA};
    done_d = nxt == FIN;
  end
endmodule

// File: tb/tb_axil_selftest_master.sv
// tb_axil_selftest_master: directed self-test runs against a configurable AXI-Lite register slave model
module tb_axil_selftest_master;
  import axil_selftest_pkg::*;
  logic ACLK = 1'b0, ARESETN = 1'b0, start = 1'b0;
  logic [31:0] seed = '0;
  logic busy, done, pass, timeout;
  logic [7:0] err_cnt;
  logic [31:0] fail_addr, awaddr, wdata, araddr, rdata;
  logic [2:0] awprot, arprot;
  logic [3:0] wstrb;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [1:0] bresp, rresp;
  int n_cmp = 0, n_bad = 0;
  bit skew = 0, ar_hold = 0, saw_split = 0;
  int corrupt_idx = -1, wr_err_idx = -1, rd_err_idx = -1, aw_cnt = 0, w_cnt = 0, lat;
  logic [31:0] mem [16];

  always #5 ACLK = ~ACLK;

  axil_selftest_master dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .seed(seed),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .fail_addr(fail_addr), .timeout(timeout),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  // slave model: updates at the falling edge, responds the cycle after each handshake
  initial begin
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs, have_aw, have_w;
    logic [3:0] wa, ra;
    logic [31:0] wd;
    int aw_wait;
    {awready, wready, arready, bvalid, rvalid, aw_hs, w_hs, b_hs, ar_hs, r_hs, have_aw, have_w} = '0;
    bresp = RESP_OKAY; rresp = RESP_OKAY; rdata = '0; wa = '0; ra = '0; wd = '0; aw_wait = 0;
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        {awready, wready, arready, bvalid, rvalid, aw_hs, w_hs, b_hs, ar_hs, r_hs, have_aw, have_w} = '0;
        aw_wait = 0;
        continue;
      end
      if (b_hs) bvalid = 1'b0;
      if (r_hs) rvalid = 1'b0;
      if (have_aw && have_w) begin
        mem[wa] = wd;
        bvalid = 1'b1;
        bresp = int'(wa) == wr_err_idx ? RESP_SLVERR : RESP_OKAY;
        have_aw = 0; have_w = 0;
      end
      if (ar_hs) begin
        rvalid = 1'b1;
        rdata = int'(ra) == corrupt_idx ? 32'hDEAD : mem[ra];
        rresp = int'(ra) == rd_err_idx ? RESP_SLVERR : RESP_OKAY;
      end
      awready = !skew || (awvalid && aw_wait >= 3);
      wready = 1'b1;
      arready = !ar_hold;
      if (awvalid && !wvalid) saw_split = 1;
      aw_hs = awvalid && awready; w_hs = wvalid && wready; b_hs = bvalid && bready;
      ar_hs = arvalid && arready; r_hs = rvalid && rready;
      if (aw_hs) begin have_aw = 1; wa = awaddr[5:2]; aw_cnt++; end
      if (w_hs) begin have_w = 1; wd = wdata; w_cnt++; end
      if (ar_hs) ra = araddr[5:2];
      aw_wait = aw_hs ? 0 : awvalid ? aw_wait + 1 : 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge ACLK);
    #2;
  endtask

  task automatic start_seq(input logic [31:0] sd);
    aw_cnt = 0; w_cnt = 0; saw_split = 0;
    seed = sd; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int l);
    l = -1;
    for (int k = 1; k <= 3000; k++) begin
      if (done) begin l = k; break; end
      tick();
    end
    chk("done_seen", 32'(l > 0), 1);
  endtask

  initial begin
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_fail_addr", fail_addr, 0);
    chk("rst_valids", {awvalid, wvalid, bready, arvalid, rready, timeout}, 0);
    ARESETN = 1'b1;
    tick(); tick();

    start_seq(32'h1);
    chk("t1_busy_n1", busy, 1);
    chk("t1_aw_w_valid_n1", {awvalid, wvalid}, 2'b11);
    chk("t1_awaddr0", awaddr, 32'h0);
    chk("t1_wdata0", wdata, 32'h1);
    chk("t1_wstrb_prot", {wstrb, awprot, arprot}, {4'hF, 6'h0});
    wait_done(lat);
    chk("t1_latency", lat, 17);
    chk("t1_busy_at_done", busy, 0);
    chk("t1_pass", pass, 1);
    chk("t1_err", err_cnt, 0);
    chk("t1_fail_addr", fail_addr, 0);
    for (int i = 0; i < 4; i++) chk("t1_mem", mem[i], 32'(i + 1));
    tick();
    chk("t1_done_pulse", done, 0);
    chk("t1_pass_held", pass, 1);
    tick();

    skew = 1;
    start_seq(32'h100);
    wait_done(lat);
    chk("t2_pass", pass, 1);
    chk("t2_aw_count", aw_cnt, 4);
    chk("t2_w_count", w_cnt, 4);
    chk("t2_w_drops_aw_held", saw_split, 1);
    chk("t2_mem3", mem[3], 32'h103);
    skew = 0;
    tick(); tick();

    corrupt_idx = 2;
    start_seq(32'h1);
    wait_done(lat);
    chk("t3_err", err_cnt, 1);
    chk("t3_fail_addr", fail_addr, 32'h8);
    chk("t3_pass", pass, 0);
    corrupt_idx = -1;
    tick(); tick();

    wr_err_idx = 1; rd_err_idx = 3;
    start_seq(32'h20);
    wait_done(lat);
    chk("t4_err", err_cnt, 2);
    chk("t4_fail_addr", fail_addr, 32'h4);
    chk("t4_pass", pass, 0);
    wr_err_idx = -1; rd_err_idx = -1;
    tick(); tick();

    ar_hold = 1;
    start_seq(32'h1);
    wait_done(lat);
    chk("t5_timeout", timeout, 1);
    chk("t5_err", err_cnt, 1);
    chk("t5_fail_addr", fail_addr, 32'h0);
    chk("t5_pass", pass, 0);
    chk("t5_arvalid", arvalid, 0);
    chk("t5_latency_min", 32'(lat >= 1000), 1);
    ar_hold = 0;
    tick(); tick();

    start_seq(32'h5);
    lat = -1;
    for (int k = 0; k < 100; k++) begin
      if (bready && awaddr == 32'h8) begin lat = k; break; end
      tick();
    end
    chk("t6_reached_wr_resp2", 32'(lat >= 0), 1);
    ARESETN = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_valids", {awvalid, wvalid, bready, arvalid, rready, done, pass, timeout}, 0);
    chk("t6_rst_err", err_cnt, 0);
    chk("t6_rst_fail_addr", fail_addr, 0);
    tick(); tick();
    ARESETN = 1'b1;
    tick(); tick();
    start_seq(32'hFFFF_FFFF);
    wait_done(lat);
    chk("t6_pass", pass, 1);
    chk("t6_err", err_cnt, 0);
    for (int i = 0; i < 4; i++) chk("t6_mem_wrap", mem[i], 32'hFFFF_FFFF + 32'(i));
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
